// File: rtl/cond_flag_gen.sv
// Multi-cycle condition evaluator: compares latched operands CHUNK bits per cycle and pulses flagUpdate with aluZero.
// Optional feature: define COND_EARLY_EXIT_EN to leave the compare on the first mismatching chunk.
module cond_flag_gen #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             flagUpdate,
  output logic             aluZero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_EQ    = 2'b00;
  localparam logic [1:0] OP_NE    = 2'b01;
  localparam logic [1:0] OP_ZERO  = 2'b10;
  localparam logic [1:0] OP_NEVER = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMP  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             mis_reg, mis_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [1:0]       op_reg, op_next;
  logic             alu_zero_reg, alu_zero_next;

  logic [N-1:0]     chunk_mis;
  logic             cur_mis;
  logic             mis_upd;
  logic             last_chunk;
  logic             leave_cmp;

  // Per-chunk mismatch; ZERO tests A against zero, EQ/NE test A against B.
  for (genvar gi = 0; gi < N; gi++) begin : g_chunk
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    assign a_chunk       = a_reg[gi*CHUNK +: CHUNK];
    assign b_chunk       = b_reg[gi*CHUNK +: CHUNK];
    assign chunk_mis[gi] = (op_reg == OP_ZERO) ? (|a_chunk) : (a_chunk != b_chunk);
  end

  assign cur_mis    = chunk_mis[cnt_reg];
  assign mis_upd    = mis_reg | cur_mis;
  assign last_chunk = (cnt_reg == CW'(N - 1));

`ifdef COND_EARLY_EXIT_EN
  assign leave_cmp = last_chunk | cur_mis;
`else
  assign leave_cmp = last_chunk;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      mis_reg      <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= OP_EQ;
      alu_zero_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      mis_reg      <= mis_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      op_reg       <= op_next;
      alu_zero_reg <= alu_zero_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    mis_next      = mis_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    op_next       = op_reg;
    alu_zero_next = alu_zero_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          a_next   = srcA;
          b_next   = srcB;
          op_next  = op;
          cnt_next = '0;
          mis_next = 1'b0;
          if (op == OP_NEVER) begin
            state_next    = DONE;
            alu_zero_next = 1'b0;
          end else begin
            state_next = CMP;
          end
        end
      end
      CMP: begin
        mis_next = mis_upd;
        if (leave_cmp) begin
          // Counter holds on exit so it never wraps past N-1.
          state_next = DONE;
          unique case (op_reg)
            OP_EQ:   alu_zero_next = ~mis_upd;
            OP_NE:   alu_zero_next = mis_upd;
            OP_ZERO: alu_zero_next = ~mis_upd;
            default: alu_zero_next = 1'b0;
          endcase
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy       = (state_reg != IDLE);
  assign flagUpdate = (state_reg == DONE);
  assign aluZero    = alu_zero_reg;

endmodule

// File: tb/tb_cond_flag_gen.sv
// Directed self-checking bench for cond_flag_gen (WIDTH=32, CHUNK=8, N=4).
// Latency expectations follow COND_EARLY_EXIT_EN when the bench is built with it.
module tb_cond_flag_gen;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic        flagUpdate;
  logic        aluZero;

  int checks_cnt;
  int fail_cnt;

  cond_flag_gen #(.WIDTH(32), .CHUNK(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .srcA       (srcA),
    .srcB       (srcB),
    .busy       (busy),
    .flagUpdate (flagUpdate),
    .aluZero    (aluZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COND_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Issues one request, measures edges from acceptance (E0) to DONE entry,
  // then checks the result and that the pulse lasts a single cycle.
  task automatic run_req(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic exp_zero);
    int lat;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val({tag, "_busy_e0"}, 32'(busy), 32'd1);
    lat = -1;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (flagUpdate) begin
        lat = k;
        break;
      end
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_zero"}, 32'(aluZero), 32'(exp_zero));
    @(posedge clk);
    #1;
    check_val({tag, "_pulse_end"}, 32'(flagUpdate), 32'd0);
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
    check_val({tag, "_zero_hold"}, 32'(aluZero), 32'(exp_zero));
  endtask

  task automatic count_idle_pulses(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (flagUpdate || busy) pulses++;
    end
    check_val({tag, "_no_pulse"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    srcA  = '0;
    srcB  = '0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_flag", 32'(flagUpdate), 32'd0);
    check_val("rst_zero", 32'(aluZero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    count_idle_pulses("rst_release", 10);

    run_req("eq_match",  2'b00, 32'h12345678, 32'h12345678, 4, 1'b1);
    run_req("eq_top",    2'b00, 32'h12345678, 32'h02345678, 4, 1'b0);
    run_req("ne_diff",   2'b01, 32'h00000000, 32'h00000001, EARLY ? 1 : 4, 1'b1);
    run_req("ne_same",   2'b01, 32'hCAFEF00D, 32'hCAFEF00D, 4, 1'b0);
    run_req("zero_nz",   2'b10, 32'h00000100, 32'hFFFFFFFF, EARLY ? 2 : 4, 1'b0);
    run_req("zero_z",    2'b10, 32'h00000000, 32'h12345678, 4, 1'b1);
    run_req("never",     2'b11, 32'h00000000, 32'h00000000, 0, 1'b0);

    // Start held high: changed inputs during CMP/DONE must be ignored.
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    srcA  = 32'hA5A5A5A5;
    srcB  = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    op   = 2'b11;
    srcA = 32'h11111111;
    srcB = 32'h22222222;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) begin
        check_val("hold_done_e4", 32'(flagUpdate), 32'd1);
        check_val("hold_zero_e4", 32'(aluZero), 32'd1);
      end
      if (k == 5) begin
        check_val("hold_idle_e5", 32'(busy), 32'd0);
      end
      if (k == 6) begin
        check_val("hold_never_e6", 32'(flagUpdate), 32'd1);
        check_val("hold_never_zero", 32'(aluZero), 32'd0);
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check_val("hold_end", 32'(flagUpdate), 32'd0);

    // Set aluZero to 1 first so that reset clearing it is observable.
    run_req("eq_pre_rst", 2'b00, 32'h0F0F0F0F, 32'h0F0F0F0F, 4, 1'b1);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    srcA  = 32'h12345678;
    srcB  = 32'h12345678;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_flag", 32'(flagUpdate), 32'd0);
    check_val("mid_rst_zero", 32'(aluZero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    count_idle_pulses("mid_rst_release", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
